// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the team's APB master and the register-file slave.
// The master modport drives the request side; the slave modport returns the response.
interface apb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB slave backed by a DEPTH-entry register file, with programmable wait states
// and an error response for out-of-range addresses. All outputs are registered.
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                pclk,
    input  logic                prstn,
    apb_slave_regfile_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [IDX_W-1:0]      lat_idx, lat_idx_n;
    logic [DATA_WIDTH-1:0] lat_wdata, lat_wdata_n;
    logic                  lat_wr, lat_wr_n;
    logic                  lat_err, lat_err_n;

    logic                  pready_q, pready_n;
    logic                  pslverr_q, pslverr_n;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_n;
    logic                  wr_en;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic                  req_err;
    logic [IDX_W-1:0]      req_idx;

    // Full-width unsigned compare, so high addresses never alias onto the file.
    assign req_err = ({1'b0, bus.paddr} >= DEPTH_L);
    assign req_idx = bus.paddr[IDX_W-1:0];

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lat_idx_n   = lat_idx;
        lat_wdata_n = lat_wdata;
        lat_wr_n    = lat_wr;
        lat_err_n   = lat_err;
        pready_n    = 1'b0;
        pslverr_n   = 1'b0;
        prdata_n    = '0;
        wr_en       = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    lat_idx_n   = req_idx;
                    lat_wdata_n = bus.pwdata;
                    lat_wr_n    = bus.pwrite;
                    lat_err_n   = req_err;
                    if (WAIT_STATES == 0) begin
                        state_n   = RESP;
                        pready_n  = 1'b1;
                        pslverr_n = req_err;
                        prdata_n  = (!bus.pwrite && !req_err) ? regs[req_idx] : '0;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (!bus.psel) begin
                    state_n = IDLE;
                end else if (bus.penable) begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_n   = RESP;
                        pready_n  = 1'b1;
                        pslverr_n = lat_err;
                        prdata_n  = (!lat_wr && !lat_err) ? regs[lat_idx] : '0;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
                wr_en   = lat_wr && bus.psel && bus.penable && !lat_err;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!prstn) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
            lat_err   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lat_idx   <= lat_idx_n;
            lat_wdata <= lat_wdata_n;
            lat_wr    <= lat_wr_n;
            lat_err   <= lat_err_n;
            pready_q  <= pready_n;
            pslverr_q <= pslverr_n;
            prdata_q  <= prdata_n;
            if (wr_en) begin
                regs[lat_idx] <= lat_wdata;
            end
        end
    end
endmodule
